// File: rtl/osc_slot_sequencer.sv
// -----------------------------------------------------------------------------
// osc_slot_sequencer
//
// Steps a (voice, oscillator) slot index through every pair once per frame to
// drive the time-multiplexed NCO / sine-lookup pipeline. It frames each sample
// period with start/end strobes. It also schedules per-voice phase-accumulator
// clears so that a note-on request always covers one complete, aligned pass
// over that voice's oscillators.
//
// Ports
//   sCLK_XVXOSC  in   slot clock, all state on the rising edge
//   reset_reg    in   asynchronous, active-high reset
//   run          in   level; 1 = keep producing frames
//   note_on      in   per-voice phase-reset request, sampled every cycle
//   vx           out  current voice index
//   ox           out  current oscillator index (fastest-changing)
//   slot_valid   out  vx/ox denote a live slot
//   frame_start  out  high with slot (0,0)
//   frame_end    out  high with slot (VOICES-1, V_OSC-1)
//   accum_zero   out  clear the phase accumulator of the current slot
//   note_ack     out  one-cycle pulse per voice when its request is scheduled
//   pending      out  requests latched but not yet scheduled
//   frame_cnt    out  completed-frame counter, wraps
// -----------------------------------------------------------------------------
module osc_slot_sequencer #(
    parameter int VOICES   = 8,
    parameter int V_OSC    = 4,
    parameter int V_WIDTH  = 3,
    parameter int O_WIDTH  = 2,
    parameter int FC_WIDTH = 8
) (
    input  logic                sCLK_XVXOSC,
    input  logic                reset_reg,
    input  logic                run,
    input  logic [VOICES-1:0]   note_on,
    output logic [V_WIDTH-1:0]  vx,
    output logic [O_WIDTH-1:0]  ox,
    output logic                slot_valid,
    output logic                frame_start,
    output logic                frame_end,
    output logic                accum_zero,
    output logic [VOICES-1:0]   note_ack,
    output logic [VOICES-1:0]   pending,
    output logic [FC_WIDTH-1:0] frame_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [V_WIDTH-1:0] LAST_VX = V_WIDTH'(VOICES - 1);
    localparam logic [O_WIDTH-1:0] LAST_OX = O_WIDTH'(V_OSC - 1);

    state_t                r_state;
    logic [V_WIDTH-1:0]    r_vx;
    logic [O_WIDTH-1:0]    r_ox;
    logic                  r_slot_valid;
    logic                  r_frame_start;
    logic                  r_frame_end;
    logic                  r_accum_zero;
    logic [VOICES-1:0]     r_note_ack;
    logic [VOICES-1:0]     r_pending;
    logic [VOICES-1:0]     r_svc;        // voice is inside its serviced pass
    logic [FC_WIDTH-1:0]   r_frame_cnt;

    state_t                w_state_nx;
    logic [V_WIDTH-1:0]    w_vx_nx;
    logic [O_WIDTH-1:0]    w_ox_nx;
    logic                  w_valid_nx;
    logic                  w_start_nx;
    logic                  w_end_nx;
    logic                  w_az_nx;
    logic [VOICES-1:0]     w_ack_nx;
    logic [VOICES-1:0]     w_pending_nx;
    logic [VOICES-1:0]     w_svc_nx;
    logic [FC_WIDTH-1:0]   w_fcnt_nx;
    logic                  w_last_slot;
    logic                  w_present_v0;

    // Next-state and next-output logic. Every output is a register, so this
    // block describes what the slot after the coming edge will look like.
    // NOTE: every variable gets a default before any branch; a path that
    // skips an assignment in a combinational block would infer a latch.
    always_comb begin
        w_state_nx = r_state;
        w_vx_nx    = '0;
        w_ox_nx    = '0;
        w_valid_nx = 1'b0;
        w_start_nx = 1'b0;
        w_end_nx   = 1'b0;
        w_fcnt_nx  = r_frame_cnt;

        w_last_slot = (r_vx == LAST_VX) && (r_ox == LAST_OX);

        case (r_state)
            IDLE: begin
                if (run) begin
                    w_state_nx = RUN;
                    w_valid_nx = 1'b1;
                    w_start_nx = 1'b1;
                end
            end
            RUN: begin
                if (w_last_slot) begin
                    // Frame boundary: the only place run is looked at, so a
                    // mid-frame drop of run never truncates the frame.
                    w_fcnt_nx = r_frame_cnt + 1'b1;
                    if (run) begin
                        w_valid_nx = 1'b1;
                        w_start_nx = 1'b1;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end else begin
                    w_valid_nx = 1'b1;
                    if (r_ox == LAST_OX) begin
                        w_ox_nx = '0;
                        w_vx_nx = r_vx + 1'b1;
                    end else begin
                        w_ox_nx = r_ox + 1'b1;
                        w_vx_nx = r_vx;
                    end
                    w_end_nx = (w_vx_nx == LAST_VX) && (w_ox_nx == LAST_OX);
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Request scheduling. A voice's service flag is loaded from the
    // registered pending bit only at the edge that presents (v,0), so the
    // accumulator clear always spans all V_OSC slots of that voice.
    always_comb begin
        w_svc_nx     = r_svc;
        w_ack_nx     = '0;
        w_present_v0 = w_valid_nx && (w_ox_nx == '0);

        // Leaving (v, V_OSC-1) ends voice v's pass. Done before the load so a
        // wrap to voice 0 cannot cancel a fresh load.
        if ((r_state == RUN) && (r_ox == LAST_OX)) begin
            w_svc_nx[r_vx] = 1'b0;
        end

        if (w_present_v0) begin
            w_svc_nx[w_vx_nx] = r_pending[w_vx_nx];
            w_ack_nx[w_vx_nx] = r_pending[w_vx_nx];
        end

        // Set wins over clear: a note_on arriving on the scheduling edge
        // leaves the request pending for the next frame.
        w_pending_nx = (r_pending & ~w_ack_nx) | note_on;
        w_az_nx      = w_valid_nx & w_svc_nx[w_vx_nx];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge sCLK_XVXOSC or posedge reset_reg) begin
        if (reset_reg) begin
            r_state       <= IDLE;
            r_vx          <= '0;
            r_ox          <= '0;
            r_slot_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_accum_zero  <= 1'b0;
            r_note_ack    <= '0;
            r_pending     <= '0;
            r_svc         <= '0;
            r_frame_cnt   <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_vx          <= w_vx_nx;
            r_ox          <= w_ox_nx;
            r_slot_valid  <= w_valid_nx;
            r_frame_start <= w_start_nx;
            r_frame_end   <= w_end_nx;
            r_accum_zero  <= w_az_nx;
            r_note_ack    <= w_ack_nx;
            r_pending     <= w_pending_nx;
            r_svc         <= w_svc_nx;
            r_frame_cnt   <= w_fcnt_nx;
        end
    end

    assign vx          = r_vx;
    assign ox          = r_ox;
    assign slot_valid  = r_slot_valid;
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;
    assign accum_zero  = r_accum_zero;
    assign note_ack    = r_note_ack;
    assign pending     = r_pending;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_osc_slot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_osc_slot_sequencer
//
// Scoreboard bench for osc_slot_sequencer (8 voices x 4 oscillators). The
// stimulus process pushes the expected content of every live slot, plus
// occasional whole-output probes, into queues; the monitor process pops and
// compares on the falling edge, away from the active clock edge.
// -----------------------------------------------------------------------------
module tb_osc_slot_sequencer;

    typedef struct packed {
        logic [2:0] vx;
        logic [1:0] ox;
        logic       fs;
        logic       fe;
        logic       az;
        logic [7:0] ack;
        logic [7:0] fc;
    } slot_t;

    typedef struct {
        string       name;
        logic [32:0] mask;
        logic [32:0] val;
    } probe_t;

    // Snapshot layout: {vx, ox, slot_valid, frame_start, frame_end,
    //                   accum_zero, note_ack, pending, frame_cnt}
    localparam logic [32:0] M_ALL   = 33'h1_FFFF_FFFF;
    localparam logic [32:0] M_PEND  = 33'h0_0000_FF00;
    localparam logic [32:0] M_VALID = 33'h0_0800_0000;
    localparam logic [32:0] M_FCNT  = 33'h0_0000_00FF;

    logic       clk       = 1'b0;
    logic       reset_reg = 1'b1;
    logic       run       = 1'b0;
    logic [7:0] note_on   = 8'h00;

    logic [2:0] vx;
    logic [1:0] ox;
    logic       slot_valid;
    logic       frame_start;
    logic       frame_end;
    logic       accum_zero;
    logic [7:0] note_ack;
    logic [7:0] pending;
    logic [7:0] frame_cnt;

    osc_slot_sequencer #(
        .VOICES  (8),
        .V_OSC   (4),
        .V_WIDTH (3),
        .O_WIDTH (2),
        .FC_WIDTH(8)
    ) dut (
        .sCLK_XVXOSC(clk),
        .reset_reg  (reset_reg),
        .run        (run),
        .note_on    (note_on),
        .vx         (vx),
        .ox         (ox),
        .slot_valid (slot_valid),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .accum_zero (accum_zero),
        .note_ack   (note_ack),
        .pending    (pending),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    slot_t      slot_q[$];
    int         tag_q[$];
    probe_t     probe_q[$];
    int         n_vec  = 0;
    int         n_miss = 0;
    bit         done   = 1'b0;

    logic [7:0] sched[32];      // note_on applied while slot s is shown
    logic [7:0] pend_exp[32];   // expected pending while slot s is shown
    bit         pend_en[32];

    wire [32:0] snap = {vx, ox, slot_valid, frame_start, frame_end,
                        accum_zero, note_ack, pending, frame_cnt};

    // ---------------------------------------------------------------- helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string name, input logic [32:0] mask,
                         input logic [32:0] val);
        probe_t p;
        p.name = name;
        p.mask = mask;
        p.val  = val;
        probe_q.push_back(p);
    endtask

    function automatic logic [32:0] pv(input logic [7:0] pend, input bit valid,
                                       input logic [7:0] fc);
        return {3'b000, 2'b00, valid, 1'b0, 1'b0, 1'b0, 8'h00, pend, fc};
    endfunction

    task automatic clear_sched();
        for (int i = 0; i < 32; i++) begin
            sched[i]    = 8'h00;
            pend_exp[i] = 8'h00;
            pend_en[i]  = 1'b0;
        end
    endtask

    task automatic setp(input int s, input logic [7:0] v);
        pend_en[s]  = 1'b1;
        pend_exp[s] = v;
    endtask

    // Expected slots of one frame: voices whose bit is set in svc get
    // accum_zero for all four oscillators and an ack on oscillator 0.
    task automatic push_frame(input logic [7:0] svc, input logic [7:0] fc,
                              input int nslots, input int tag);
        for (int s = 0; s < nslots; s++) begin
            slot_t e;
            int    v;
            v     = s / 4;
            e.vx  = 3'(v);
            e.ox  = 2'(s % 4);
            e.fs  = (s == 0);
            e.fe  = (s == 31);
            e.az  = svc[v];
            e.ack = ((s % 4 == 0) && svc[v]) ? 8'(1 << v) : 8'h00;
            e.fc  = fc;
            slot_q.push_back(e);
            tag_q.push_back(tag * 32 + s);
        end
    endtask

    // Entered in the cycle before slot 0 with run already high; returns in
    // the slot-31 cycle.
    task automatic play_frame(input logic [7:0] svc, input logic [7:0] fc,
                              input int drop_slot, input int tag);
        push_frame(svc, fc, 32, tag);
        for (int s = 0; s < 32; s++) begin
            tick();
            note_on = sched[s];
            if (s == drop_slot) run = 1'b0;
            if (pend_en[s])
                probe($sformatf("pending_f%0d_s%0d", tag, s), M_PEND,
                      pv(pend_exp[s], 1'b0, 8'h00));
        end
    endtask

    // ---------------------------------------------------------------- monitor
    slot_t  m_got;
    slot_t  m_exp;
    int     m_tag;
    probe_t m_p;

    always @(negedge clk) begin
        if (probe_q.size() > 0) begin
            m_p = probe_q.pop_front();
            n_vec++;
            if ((snap & m_p.mask) !== m_p.val) begin
                n_miss++;
                $display("FAIL %s: got %h (masked %h), want %h, mask %h",
                         m_p.name, snap, snap & m_p.mask, m_p.val, m_p.mask);
            end
        end
        if (slot_valid === 1'b1) begin
            n_vec++;
            if (slot_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_slot: got vx=%0d ox=%0d fc=%0d, want no live slot",
                         vx, ox, frame_cnt);
            end else begin
                m_exp = slot_q.pop_front();
                m_tag = tag_q.pop_front();
                m_got = {vx, ox, frame_start, frame_end, accum_zero, note_ack, frame_cnt};
                if (m_got !== m_exp) begin
                    n_miss++;
                    $display("FAIL slot f%0d_s%0d: got vx=%0d ox=%0d fs=%b fe=%b az=%b ack=%h fc=%0d, want vx=%0d ox=%0d fs=%b fe=%b az=%b ack=%h fc=%0d",
                             m_tag / 32, m_tag % 32,
                             m_got.vx, m_got.ox, m_got.fs, m_got.fe, m_got.az, m_got.ack, m_got.fc,
                             m_exp.vx, m_exp.ox, m_exp.fs, m_exp.fe, m_exp.az, m_exp.ack, m_exp.fc);
                end
            end
        end
        if (done) begin
            n_vec++;
            if (slot_q.size() != 0 || probe_q.size() != 0) begin
                n_miss++;
                $display("FAIL leftover: got %0d slots and %0d probes unconsumed, want 0",
                         slot_q.size(), probe_q.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
            $finish;
        end
    end

    // --------------------------------------------------------------- stimulus
    initial begin
        clear_sched();
        tick();
        tick();
        probe("reset_hold", M_ALL, 33'h0);
        tick();
        reset_reg = 1'b0;
        tick();
        probe("idle_after_reset", M_ALL, 33'h0);
        tick();

        // Frame 0: sequencing, note_on[3] at slot 5 serviced at slots 12..15.
        clear_sched();
        sched[5] = 8'h08;
        setp(5, 8'h00); setp(6, 8'h08); setp(11, 8'h08); setp(12, 8'h00);
        run = 1'b1;
        play_frame(8'h08, 8'd0, 99, 0);

        // Frame 1: late request at slot 13 while voice 3 is active.
        clear_sched();
        sched[13] = 8'h08;
        setp(13, 8'h00); setp(14, 8'h08); setp(31, 8'h08);
        play_frame(8'h00, 8'd1, 99, 1);

        // Frame 2: late request serviced; voice 2 set at slot 6 and again on
        // the edge presenting (2,0): serviced now and still pending.
        clear_sched();
        sched[6] = 8'h04;
        sched[7] = 8'h04;
        setp(6, 8'h08); setp(7, 8'h0C); setp(8, 8'h0C); setp(12, 8'h04); setp(31, 8'h04);
        play_frame(8'h0C, 8'd2, 99, 2);

        // Frame 3: voice 2 serviced again; voice 6 requested twice merges into
        // one service; run drops at slot 10 but the frame completes.
        clear_sched();
        sched[1] = 8'h40;
        sched[2] = 8'h40;
        setp(1, 8'h04); setp(2, 8'h44); setp(3, 8'h44); setp(8, 8'h40); setp(24, 8'h00);
        play_frame(8'h44, 8'd3, 10, 3);
        tick();
        probe("stopped", M_VALID | M_FCNT | M_PEND, pv(8'h00, 1'b0, 8'd4));

        // Request latched while IDLE, serviced at slot 0 of the next frame.
        note_on = 8'h01;
        tick();
        note_on = 8'h00;
        probe("idle_latch", M_ALL, pv(8'h01, 1'b0, 8'd4));
        tick();
        clear_sched();
        setp(0, 8'h00);
        run = 1'b1;
        play_frame(8'h01, 8'd4, 99, 4);

        // Frames 5..256: frame_cnt wraps 255 -> 0; stop after frame 256.
        clear_sched();
        for (int f = 5; f <= 256; f++)
            play_frame(8'h00, 8'(f), (f == 256) ? 0 : 99, f);
        tick();
        probe("wrapped_idle", M_VALID | M_FCNT, pv(8'h00, 1'b0, 8'd1));

        // Reset mid-frame with voice 7 still pending.
        note_on = 8'h80;
        tick();
        note_on = 8'h00;
        run = 1'b1;
        push_frame(8'h00, 8'd1, 9, 257);
        repeat (9) tick();
        probe("pending_before_reset", M_PEND | M_VALID, pv(8'h80, 1'b1, 8'h00));
        tick();
        reset_reg = 1'b1;
        run = 1'b0;
        probe("async_reset", M_ALL, 33'h0);
        tick();
        tick();
        reset_reg = 1'b0;
        tick();
        tick();
        probe("idle_after_release", M_ALL, 33'h0);
        tick();
        done = 1'b1;
    end

endmodule
